leaf_interface_tx: RTL and testbench

LEAF_INTERFACE_TX -- requirements
Module: leaf_interface_tx

---
 rtl/bft_pkg.sv | 31 +++
 rtl/leaf_sync_fifo.sv | 58 +++++
 rtl/leaf_interface_tx.sv | 142 ++++++++++++++
 tb/tb_leaf_interface_tx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bft_pkg.sv
// Shared BFT leaf packet layout, config-port default and transmit FSM states.
// Reused by the leaf transmit and receive interfaces.
package bft_pkg;

    localparam int PKT_W    = 49;
    localparam int VLD_BIT  = 48;
    localparam int LEAF_LSB = 43;
    localparam int LEAF_W   = 5;
    localparam int PORT_LSB = 39;
    localparam int PORT_W   = 4;
    localparam int SEQ_LSB  = 32;
    localparam int SEQ_W    = 7;
    localparam int PAY_W    = 32;

    localparam logic [PORT_W-1:0] CFG_PORT_DEFAULT = 4'd0;

    typedef struct packed {
        logic              vld;
        logic [LEAF_W-1:0] leaf;
        logic [PORT_W-1:0] port;
        logic [SEQ_W-1:0]  seq;
        logic [PAY_W-1:0]  payload;
    } bft_pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SEND  = 2'd2
    } bft_state_e;

endpackage

// File: rtl/leaf_sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count.
// Latency: write visible at head one cycle later; backpressure: push ignored when full, pop ignored when empty.
module leaf_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);

endmodule

// File: rtl/leaf_interface_tx.sv
// Leaf-to-BFT transmit interface: buffers operator words and sends them as headed packets.
// Latency: first packet one cycle after arming with data; backpressure: s_ready from registered FIFO count, resend holds the packet.
module leaf_interface_tx
    import bft_pkg::*;
#(
    parameter int                FIFO_DEPTH = 16,
    parameter logic [PORT_W-1:0] CFG_PORT   = CFG_PORT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ap_start,
    input  logic [PKT_W-1:0] din_leaf_bft2interface,
    output logic [PKT_W-1:0] dout_leaf_interface2bft,
    input  logic             resend,
    input  logic [PAY_W-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [15:0]      sent_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    bft_state_e        r_state;
    bft_state_e        w_state_nxt;
    logic              r_cfg_valid;
    logic [LEAF_W-1:0] r_dest_leaf;
    logic [PORT_W-1:0] r_dest_port;
    logic [SEQ_W-1:0]  r_seq;
    logic [15:0]       r_sent;
    logic              r_held;
    logic [LEAF_W-1:0] r_hdr_leaf;
    logic [PORT_W-1:0] r_hdr_port;

    bft_pkt_t          w_din;
    bft_pkt_t          w_pkt;
    logic              w_cfg_hit;
    logic              w_push;
    logic              w_in_send;
    logic              w_accept;
    logic              w_drain;
    logic [PAY_W-1:0]  w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_unused_din;

    assign w_din        = bft_pkt_t'(din_leaf_bft2interface);
    assign w_cfg_hit    = w_din.vld && (w_din.port == CFG_PORT);
    assign w_unused_din = ^{w_din.leaf, w_din.seq, w_din.payload[PAY_W-1:9]};

    assign s_ready   = !w_full;
    assign w_push    = s_valid && s_ready;
    assign w_in_send = (r_state == ST_SEND);
    assign w_accept  = w_in_send && !resend;
    // FIFO will be empty after this accept unless a word arrives in the same cycle.
    assign w_drain   = (w_count == CNT_W'(1)) && !w_push;

    leaf_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAY_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (s_data),
        .i_pop      (w_accept),
        .o_head_dat (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_valid <= 1'b0;
            r_dest_leaf <= '0;
            r_dest_port <= '0;
        end else if (w_cfg_hit) begin
            r_cfg_valid <= 1'b1;
            r_dest_leaf <= w_din.payload[8:4];
            r_dest_port <= w_din.payload[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (r_cfg_valid) w_state_nxt = ST_ARMED;
            ST_ARMED: if (ap_start && !w_empty) w_state_nxt = ST_SEND;
            ST_SEND:  if (w_accept && (w_drain || !ap_start)) w_state_nxt = ST_ARMED;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // A rejected packet freezes the header it was first shown with.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_held     <= 1'b0;
            r_hdr_leaf <= '0;
            r_hdr_port <= '0;
        end else if (w_in_send && resend && !r_held) begin
            r_held     <= 1'b1;
            r_hdr_leaf <= r_dest_leaf;
            r_hdr_port <= r_dest_port;
        end else if (w_accept) begin
            r_held     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq  <= '0;
            r_sent <= '0;
        end else if (w_accept) begin
            r_seq  <= r_seq + SEQ_W'(1);
            r_sent <= r_sent + 16'd1;
        end
    end

    always_comb begin
        w_pkt = '0;
        if (w_in_send) begin
            w_pkt.vld     = 1'b1;
            w_pkt.leaf    = r_held ? r_hdr_leaf : r_dest_leaf;
            w_pkt.port    = r_held ? r_hdr_port : r_dest_port;
            w_pkt.seq     = r_seq;
            w_pkt.payload = w_head;
        end
    end

    assign dout_leaf_interface2bft = w_pkt;
    assign sent_count              = r_sent;

endmodule

// File: tb/tb_leaf_interface_tx.sv
// Scoreboarded bench for leaf_interface_tx: config capture, streaming, resend, full FIFO, seq wrap, reset.
module tb_leaf_interface_tx;
    import bft_pkg::*;

    logic             clk;
    logic             reset;
    logic             ap_start;
    logic [PKT_W-1:0] din;
    logic [PKT_W-1:0] dout;
    logic             resend;
    logic [31:0]      s_data;
    logic             s_valid;
    logic             s_ready;
    logic [15:0]      sent_count;

    int errors = 0;
    int checks = 0;

    logic [38:0] sb_q[$];
    logic [6:0]  push_seq;
    logic [4:0]  m_leaf;
    logic [3:0]  m_port;
    logic [6:0]  last_seq;
    bit          have_last;
    bit          saw_wrap;

    leaf_interface_tx #(
        .FIFO_DEPTH (16),
        .CFG_PORT   (4'd0)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .ap_start                (ap_start),
        .din_leaf_bft2interface  (din),
        .dout_leaf_interface2bft (dout),
        .resend                  (resend),
        .s_data                  (s_data),
        .s_valid                 (s_valid),
        .s_ready                 (s_ready),
        .sent_count              (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; ap_start = 1'b0; resend = 1'b0; s_valid = 1'b0; s_data = '0; din = '0;
        step();
        step();
        reset = 1'b0;
        sb_q.delete();
        push_seq = '0; m_leaf = '0; m_port = '0; have_last = 1'b0;
    endtask

    task automatic send_cfg(input logic [31:0] pay);
        din = {1'b1, 5'd0, 4'd0, 7'd0, pay};
        step();
        din = '0;
        m_leaf = pay[8:4];
        m_port = pay[3:0];
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        ap_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_data  = base + 32'(i);
            s_valid = 1'b1;
            if (s_ready) begin
                sb_q.push_back({push_seq, s_data});
                push_seq = push_seq + 7'd1;
            end
            step();
        end
        s_valid = 1'b0;
    endtask

    // Drains n packets, asserting resend for rs_len cycles on packet rs_idx; a nonzero
    // cfg_pay is injected as a config packet in the middle of that resend window.
    task automatic drain(input int n, input int rs_idx, input int rs_len, input logic [31:0] cfg_pay);
        int got = 0;
        int cyc = 0;
        int gaps = 0;
        int rs_left = 0;
        bit fresh = 1'b1;
        bit started = 1'b0;
        bit cfg_pend = 1'b0;
        logic [48:0] exp_pkt = '0;
        logic [6:0]  cur;
        ap_start = 1'b1;
        while (got < n && cyc < n * 8 + 40) begin
            if (dout[48]) begin
                started = 1'b1;
                if (fresh) begin
                    exp_pkt = {1'b1, m_leaf, m_port, sb_q[0]};
                    fresh = 1'b0;
                    rs_left = (got == rs_idx) ? rs_len : 0;
                end
                checks++;
                if (dout !== exp_pkt) begin
                    errors++;
                    $display("FAIL pkt%0d: got %h expected %h", got, dout, exp_pkt);
                end
                if (rs_left > 0) begin
                    resend = 1'b1;
                    rs_left--;
                    if (cfg_pay != 0 && rs_left == 1) begin
                        din = {1'b1, 5'd0, 4'd0, 7'd0, cfg_pay};
                        cfg_pend = 1'b1;
                    end
                end else begin
                    resend = 1'b0;
                    cur = exp_pkt[38:32];
                    if (have_last && last_seq == 7'd127 && cur == 7'd0) saw_wrap = 1'b1;
                    last_seq = cur;
                    have_last = 1'b1;
                    void'(sb_q.pop_front());
                    got++;
                    fresh = 1'b1;
                end
            end else begin
                resend = 1'b0;
                if (started) gaps++;
            end
            step();
            din = '0;
            if (cfg_pend) begin
                m_leaf = cfg_pay[8:4];
                m_port = cfg_pay[3:0];
                cfg_pend = 1'b0;
            end
            cyc++;
        end
        resend = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL drain_timeout: got %0d packets required %0d", got, n);
        end
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL throughput_gaps: got %0d idle cycles required 0", gaps);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dout !== 49'd0) begin errors++; $display("FAIL rst_dout: got %h expected 0", dout); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b expected 1", s_ready); end
        checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL rst_sent: got %0d expected 0", sent_count); end
        checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dut.r_state, ST_IDLE); end
        checks++; if (int'(dut.u_fifo.r_count) != 0) begin errors++; $display("FAIL rst_occ: got %0d expected 0", dut.u_fifo.r_count); end
    endtask

    task automatic test_config();
        din = {1'b1, 5'd0, 4'd2, 7'd0, 32'h0000_01FF};
        step();
        din = {1'b0, 5'd0, 4'd0, 7'd0, 32'h0000_01FF};
        step();
        din = '0;
        checks++;
        if (dut.r_cfg_valid !== 1'b0 || dut.r_dest_leaf !== 5'h00 || dut.r_dest_port !== 4'h0) begin
            errors++;
            $display("FAIL cfg_ignore: got v=%b leaf=%h port=%h expected 0/00/0", dut.r_cfg_valid, dut.r_dest_leaf, dut.r_dest_port);
        end
        send_cfg(32'h0000_0153);
        checks++; if (dut.r_dest_leaf !== 5'h15) begin errors++; $display("FAIL cfg_leaf: got %h expected 15", dut.r_dest_leaf); end
        checks++; if (dut.r_dest_port !== 4'h3) begin errors++; $display("FAIL cfg_port: got %h expected 3", dut.r_dest_port); end
        step();
        checks++; if (dut.r_state !== ST_ARMED) begin errors++; $display("FAIL cfg_state: got %0d expected %0d", dut.r_state, ST_ARMED); end
        checks++; if (dout !== 49'd0) begin errors++; $display("FAIL armed_dout: got %h expected 0", dout); end
    endtask

    task automatic test_stream();
        push_words(4, 32'h0000_00A0);
        drain(4, -1, 0, 32'd0);
        checks++; if (dout !== 49'd0) begin errors++; $display("FAIL stream_idle_dout: got %h expected 0", dout); end
        checks++; if (sent_count !== 16'd4) begin errors++; $display("FAIL stream_sent: got %0d expected 4", sent_count); end
    endtask

    task automatic test_resend();
        do_reset();
        send_cfg(32'h0000_0153);
        push_words(4, 32'h0000_00A0);
        drain(4, 2, 3, 32'h0000_00A7);
        checks++; if (sent_count !== 16'd4) begin errors++; $display("FAIL resend_sent: got %0d expected 4", sent_count); end
    endtask

    task automatic test_full();
        ap_start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (s_ready !== (i < 16)) begin
                errors++;
                $display("FAIL full_s_ready%0d: got %b expected %b", i, s_ready, (i < 16));
            end
            s_data  = 32'hF000_0000 + 32'(i);
            s_valid = 1'b1;
            if (s_ready) begin
                sb_q.push_back({push_seq, s_data});
                push_seq = push_seq + 7'd1;
            end
            step();
        end
        s_valid = 1'b0;
        checks++; if (int'(dut.u_fifo.r_count) != 16) begin errors++; $display("FAIL full_occ: got %0d expected 16", dut.u_fifo.r_count); end
        ap_start = 1'b1;
        step();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_pop_s_ready: got %b expected 0", s_ready); end
        drain(16, -1, 0, 32'd0);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_after_s_ready: got %b expected 1", s_ready); end
        checks++; if (sent_count !== 16'd20) begin errors++; $display("FAIL full_sent: got %0d expected 20", sent_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        send_cfg(32'h0000_0153);
        saw_wrap = 1'b0;
        for (int b = 0; b < 10; b++) begin
            push_words(13, 32'hC000_0000 + 32'(b * 13));
            drain(13, -1, 0, 32'd0);
        end
        checks++; if (sent_count !== 16'd130) begin errors++; $display("FAIL wrap_sent: got %0d expected 130", sent_count); end
        checks++; if (saw_wrap !== 1'b1) begin errors++; $display("FAIL wrap_seq: got %b expected 1", saw_wrap); end
    endtask

    task automatic test_reset_mid_resend();
        int cyc = 0;
        push_words(3, 32'h0000_D000);
        ap_start = 1'b1;
        while (!dout[48] && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (!dout[48]) begin
            errors++;
            $display("FAIL rmr_start: got %b expected 1", dout[48]);
        end
        resend = 1'b0;
        step();
        checks++; if (sent_count !== 16'd131) begin errors++; $display("FAIL rmr_sent_pre: got %0d expected 131", sent_count); end
        resend = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        resend = 1'b0;
        checks++; if (dout !== 49'd0) begin errors++; $display("FAIL rmr_dout: got %h expected 0", dout); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rmr_s_ready: got %b expected 1", s_ready); end
        checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL rmr_sent: got %0d expected 0", sent_count); end
        checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL rmr_state: got %0d expected %0d", dut.r_state, ST_IDLE); end
        checks++; if (int'(dut.u_fifo.r_count) != 0) begin errors++; $display("FAIL rmr_occ: got %0d expected 0", dut.u_fifo.r_count); end
        sb_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ap_start = 1'b0; resend = 1'b0; s_valid = 1'b0; s_data = '0; din = '0;
        push_seq = '0; m_leaf = '0; m_port = '0; last_seq = '0; have_last = 1'b0; saw_wrap = 1'b0;
        test_reset();
        test_config();
        test_stream();
        test_resend();
        test_full();
        test_wrap();
        test_reset_mid_resend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
